// File: rtl/pll_lock_supervisor_pkg.sv
//============================================================================
// Module      : pll_sup_pkg
// Description : State encodings and shared constants for the PLL lock
//               supervisor.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_ARM        = 3'd3,
        ST_CHECK      = 3'd4,
        ST_RUN        = 3'd5
    } state_t;

    // Window in which USR_PLL_LOCKED_STDY must follow the steady-lock reset pulse.
    localparam int CHECK_CYCLES = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_supervisor_if.sv
//============================================================================
// Module      : pll_sup_if
// Description : PLL-side flags, system reset and status of the lock supervisor.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface pll_sup_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked_in;
    logic             pll_locked_stdy_in;
    logic             restart_req;
    logic             pll_stdy_rst;
    logic             sys_rst_n_out;
    logic             ready;
    logic             lock_timeout;
    logic [CNT_W-1:0] unlock_count;
    logic [2:0]       state_out;

    // The supervisor side drives the reset and status outputs.
    modport master (
        input  pll_locked_in,
        input  pll_locked_stdy_in,
        input  restart_req,
        output pll_stdy_rst,
        output sys_rst_n_out,
        output ready,
        output lock_timeout,
        output unlock_count,
        output state_out
    );

    modport slave (
        output pll_locked_in,
        output pll_locked_stdy_in,
        output restart_req,
        input  pll_stdy_rst,
        input  sys_rst_n_out,
        input  ready,
        input  lock_timeout,
        input  unlock_count,
        input  state_out
    );

endinterface

`default_nettype wire

// File: rtl/pll_lock_supervisor_sync_2ff.sv
//============================================================================
// Module      : sync_2ff
// Description : Two-flop single-bit synchronizer with selectable reset value.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
//============================================================================
// Module      : pll_lock_supervisor
// Description : Brings up a CC_PLL, arms steady-lock tracking and gates the
//               downstream system reset on a stable lock.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int SETTLE_CYCLES   = 1024,
    parameter int STDY_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT    = 100000,
    parameter int CNT_W           = 8
) (
    input  wire logic  clock_in,
    input  wire logic  rst_n_in,
    pll_sup_if.master  pll_if
);

    // The shared timer also times the arm pulse and the check window.
    localparam int c_timer_max = max_int(max_int(HOLD_CYCLES, SETTLE_CYCLES),
                                         max_int(LOCK_TIMEOUT,
                                                 max_int(STDY_RST_CYCLES, CHECK_CYCLES)));
    localparam int c_timer_w   = $clog2(c_timer_max + 1);

    localparam logic [c_timer_w-1:0] c_hold_last    = c_timer_w'(HOLD_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_settle_last  = c_timer_w'(SETTLE_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_stdy_last    = c_timer_w'(STDY_RST_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_check_last   = c_timer_w'(CHECK_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(LOCK_TIMEOUT - 1);

    state_t                 r_state;
    logic [c_timer_w-1:0]   r_timer;
    logic                   r_stdy_rst;
    logic                   r_sys_rst_n;
    logic                   r_ready;
    logic                   r_lock_timeout;
    logic [CNT_W-1:0]       r_unlock_count;

    logic                   w_lock_s;
    logic                   w_stdy_s;
    logic                   w_lost;
    logic                   w_restart;
    logic [c_timer_w-1:0]   w_timer_inc;
    logic [c_timer_w-1:0]   w_wait_next;

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_lock (
        .clk   (clock_in),
        .rst_n (rst_n_in),
        .i_d   (pll_if.pll_locked_in),
        .o_q   (w_lock_s)
    );

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_stdy (
        .clk   (clock_in),
        .rst_n (rst_n_in),
        .i_d   (pll_if.pll_locked_stdy_in),
        .o_q   (w_stdy_s)
    );

    assign w_lost      = !w_lock_s || !w_stdy_s;
    assign w_restart   = pll_if.restart_req && (r_state != ST_RESET_HOLD);
    assign w_timer_inc = r_timer + c_timer_w'(1);
    // The wait timer parks at its last value so the timeout flag stays meaningful.
    assign w_wait_next = (r_timer == c_timeout_last) ? r_timer : w_timer_inc;

    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= ST_RESET_HOLD;
            r_timer        <= '0;
            r_stdy_rst     <= 1'b0;
            r_sys_rst_n    <= 1'b0;
            r_ready        <= 1'b0;
            r_lock_timeout <= 1'b0;
            r_unlock_count <= '0;
        end else begin
            // A lock loss in RUN is counted even when a restart wins the next state.
            if ((r_state == ST_RUN) && w_lost && (r_unlock_count != '1)) begin
                r_unlock_count <= r_unlock_count + CNT_W'(1);
            end

            if (w_restart) begin
                r_state     <= ST_RESET_HOLD;
                r_timer     <= '0;
                r_stdy_rst  <= 1'b0;
                r_sys_rst_n <= 1'b0;
                r_ready     <= 1'b0;
            end else begin
                case (r_state)
                    ST_RESET_HOLD: begin
                        if (r_timer == c_hold_last) begin
                            r_state <= ST_WAIT_LOCK;
                            r_timer <= '0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end

                    ST_WAIT_LOCK: begin
                        if (w_lock_s) begin
                            r_state <= ST_SETTLE;
                            r_timer <= '0;
                        end else begin
                            r_timer <= w_wait_next;
                            if (w_wait_next == c_timeout_last) begin
                                r_lock_timeout <= 1'b1;
                            end
                        end
                    end

                    ST_SETTLE: begin
                        if (!w_lock_s) begin
                            r_state <= ST_WAIT_LOCK;
                            r_timer <= '0;
                        end else if (r_timer == c_settle_last) begin
                            r_state    <= ST_ARM;
                            r_timer    <= '0;
                            r_stdy_rst <= 1'b1;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end

                    ST_ARM: begin
                        if (!w_lock_s) begin
                            r_state    <= ST_WAIT_LOCK;
                            r_timer    <= '0;
                            r_stdy_rst <= 1'b0;
                        end else if (r_timer == c_stdy_last) begin
                            r_state    <= ST_CHECK;
                            r_timer    <= '0;
                            r_stdy_rst <= 1'b0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end

                    ST_CHECK: begin
                        if (!w_lock_s) begin
                            r_state <= ST_WAIT_LOCK;
                            r_timer <= '0;
                        end else if (w_stdy_s) begin
                            r_state     <= ST_RUN;
                            r_timer     <= '0;
                            r_sys_rst_n <= 1'b1;
                            r_ready     <= 1'b1;
                        end else if (r_timer == c_check_last) begin
                            r_state <= ST_WAIT_LOCK;
                            r_timer <= '0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end

                    ST_RUN: begin
                        if (w_lost) begin
                            r_state     <= ST_WAIT_LOCK;
                            r_timer     <= '0;
                            r_sys_rst_n <= 1'b0;
                            r_ready     <= 1'b0;
                        end
                    end

                    default: begin
                        r_state     <= ST_RESET_HOLD;
                        r_timer     <= '0;
                        r_stdy_rst  <= 1'b0;
                        r_sys_rst_n <= 1'b0;
                        r_ready     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_if.pll_stdy_rst  = r_stdy_rst;
    assign pll_if.sys_rst_n_out = r_sys_rst_n;
    assign pll_if.ready         = r_ready;
    assign pll_if.lock_timeout  = r_lock_timeout;
    assign pll_if.unlock_count  = r_unlock_count;
    assign pll_if.state_out     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
//============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Self-checking bench for the PLL lock supervisor.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    localparam int HOLD    = 4;
    localparam int SETTLE  = 8;
    localparam int STDY    = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_sup_if #(.CNT_W(CW)) u_if ();

    pll_lock_supervisor #(
        .HOLD_CYCLES     (HOLD),
        .SETTLE_CYCLES   (SETTLE),
        .STDY_RST_CYCLES (STDY),
        .LOCK_TIMEOUT    (TIMEOUT),
        .CNT_W           (CW)
    ) u_dut (
        .clock_in (clk),
        .rst_n_in (rst_n),
        .pll_if   (u_if)
    );

    typedef struct {
        int state;
        bit stdy_rst;
        bit sys;
        bit rdy;
    } obs_t;

    typedef struct {
        int first;
        int last;
        int state;
        bit stdy_rst;
        bit sys;
        bit rdy;
    } seg_t;

    obs_t exp_q[$];
    seg_t segs[6];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_obs(input string name, input obs_t e);
        obs_t a;
        a.state    = int'(u_if.state_out);
        a.stdy_rst = u_if.pll_stdy_rst;
        a.sys      = u_if.sys_rst_n_out;
        a.rdy      = u_if.ready;
        n_cmp++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got state=%0d stdy_rst=%0d sys_rst_n=%0d ready=%0d expected state=%0d stdy_rst=%0d sys_rst_n=%0d ready=%0d",
                     name, a.state, a.stdy_rst, a.sys, a.rdy, e.state, e.stdy_rst, e.sys, e.rdy);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_state"},    int'(u_if.state_out),     int'(ST_RESET_HOLD));
        check({name, "_stdy_rst"}, int'(u_if.pll_stdy_rst),  0);
        check({name, "_sys_rst"},  int'(u_if.sys_rst_n_out), 0);
        check({name, "_ready"},    int'(u_if.ready),         0);
        check({name, "_timeout"},  int'(u_if.lock_timeout),  0);
        check({name, "_count"},    int'(u_if.unlock_count),  0);
    endtask

    task automatic wait_state(input string name, input int st, input int budget);
        int n = 0;
        while ((int'(u_if.state_out) != st) && (n < budget)) begin
            tick();
            n++;
        end
        check({name, "_reached"}, int'(int'(u_if.state_out) == st), 1);
    endtask

    // Lock rises, steady-lock follows two cycles after the arm pulse ends.
    task automatic bring_up(input string name);
        int n  = 0;
        int hi = 0;
        u_if.pll_locked_in = 1'b1;
        while (!u_if.pll_stdy_rst && (n < 300)) begin
            tick();
            n++;
        end
        check({name, "_arm_seen"}, int'(u_if.pll_stdy_rst), 1);
        while (u_if.pll_stdy_rst && (hi < 20)) begin
            tick();
            hi++;
        end
        check({name, "_stdy_rst_width"}, hi, STDY);
        tick();
        tick();
        u_if.pll_locked_stdy_in = 1'b1;
        wait_state({name, "_run"}, int'(ST_RUN), 20);
        check({name, "_sys_rst_n"}, int'(u_if.sys_rst_n_out), 1);
        check({name, "_ready"},     int'(u_if.ready),         1);
    endtask

    task automatic lose_lock(input string name, input bit only_stdy);
        int n = 0;
        if (!only_stdy) u_if.pll_locked_in = 1'b0;
        u_if.pll_locked_stdy_in = 1'b0;
        while (u_if.sys_rst_n_out && (n < 10)) begin
            tick();
            n++;
        end
        n_cmp++;
        if (u_if.sys_rst_n_out || (n > 3) || (n < 1)) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges (sys_rst_n=%0d) expected 1..3 edges and sys_rst_n=0",
                     name, n, u_if.sys_rst_n_out);
        end
        check({name, "_ready_low"}, int'(u_if.ready), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fall_k;
        bit   prev_stdy;
        obs_t e;
        int   n;
        int   run_len;
        bit   saw_wl;
        bit   early;

        segs[0] = '{0,  3,  int'(ST_RESET_HOLD), 1'b0, 1'b0, 1'b0};
        segs[1] = '{4,  12, int'(ST_WAIT_LOCK),  1'b0, 1'b0, 1'b0};
        segs[2] = '{13, 20, int'(ST_SETTLE),     1'b0, 1'b0, 1'b0};
        segs[3] = '{21, 24, int'(ST_ARM),        1'b1, 1'b0, 1'b0};
        segs[4] = '{25, 29, int'(ST_CHECK),      1'b0, 1'b0, 1'b0};
        segs[5] = '{30, 34, int'(ST_RUN),        1'b0, 1'b1, 1'b1};

        u_if.pll_locked_in      = 1'b0;
        u_if.pll_locked_stdy_in = 1'b0;
        u_if.restart_req        = 1'b0;

        // ---- 1. clean bring-up, cycle-exact against the segment table
        repeat (3) tick();
        check_reset_values("reset");
        rst_n     = 1'b1;
        fall_k    = -10;
        prev_stdy = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            for (int s = 0; s < 6; s++) begin
                if ((k >= segs[s].first) && (k <= segs[s].last)) begin
                    e.state    = segs[s].state;
                    e.stdy_rst = segs[s].stdy_rst;
                    e.sys      = segs[s].sys;
                    e.rdy      = segs[s].rdy;
                    exp_q.push_back(e);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_obs($sformatf("bringup_cycle%0d", k), e);
            end
            if (prev_stdy && !u_if.pll_stdy_rst) fall_k = k;
            prev_stdy = u_if.pll_stdy_rst;
            if (k == 10) u_if.pll_locked_in = 1'b1;
            if (k == fall_k + 2) u_if.pll_locked_stdy_in = 1'b1;
            tick();
        end
        check("bringup_count",   int'(u_if.unlock_count), 0);
        check("bringup_timeout", int'(u_if.lock_timeout), 0);

        // ---- 3. lock loss in RUN and relock
        lose_lock("loss1", 1'b0);
        check("loss1_state", int'(u_if.state_out),    int'(ST_WAIT_LOCK));
        check("loss1_count", int'(u_if.unlock_count), 1);
        bring_up("relock1");

        // ---- 2. glitchy lock during SETTLE
        lose_lock("loss2", 1'b0);
        u_if.pll_locked_in = 1'b1;
        wait_state("glitch_settle", int'(ST_SETTLE), 20);
        repeat (4) tick();
        u_if.pll_locked_in = 1'b0;
        tick();
        u_if.pll_locked_in = 1'b1;
        saw_wl  = 1'b0;
        early   = 1'b0;
        run_len = 0;
        n       = 0;
        while ((int'(u_if.state_out) != int'(ST_ARM)) && (n < 60)) begin
            if (int'(u_if.state_out) == int'(ST_WAIT_LOCK)) begin
                saw_wl  = 1'b1;
                run_len = 0;
            end else if (int'(u_if.state_out) == int'(ST_SETTLE)) begin
                run_len++;
            end
            if (u_if.pll_stdy_rst) early = 1'b1;
            tick();
            n++;
        end
        check("glitch_back_to_wait",  int'(saw_wl), 1);
        check("glitch_settle_length", run_len, SETTLE);
        check("glitch_no_early_arm",  int'(early), 0);
        check("glitch_count",         int'(u_if.unlock_count), 2);
        bring_up("glitch");

        // ---- 3b. repeated losses until the counter saturates
        for (int i = 3; i <= 300; i++) begin
            lose_lock($sformatf("loss%0d", i), (i == 3));
            check($sformatf("count_after_loss%0d", i), int'(u_if.unlock_count), (i > 255) ? 255 : i);
            bring_up($sformatf("relock%0d", i));
        end
        check("count_saturated", int'(u_if.unlock_count), 255);

        // ---- 4. lock timeout
        rst_n = 1'b0;
        u_if.pll_locked_in      = 1'b0;
        u_if.pll_locked_stdy_in = 1'b0;
        #2;
        check_reset_values("reset2");
        tick();
        rst_n = 1'b1;
        wait_state("timeout_wait", int'(ST_WAIT_LOCK), 10);
        for (int c = 1; c <= 80; c++) begin
            check($sformatf("timeout_wl_cycle%0d", c), int'(u_if.lock_timeout), (c >= TIMEOUT) ? 1 : 0);
            tick();
        end
        check("timeout_still_waiting", int'(u_if.state_out), int'(ST_WAIT_LOCK));
        bring_up("late_lock");
        check("late_lock_timeout_sticky", int'(u_if.lock_timeout), 1);
        check("late_lock_count",          int'(u_if.unlock_count), 0);

        // ---- 5a. restart_req coinciding with lock loss in RUN
        u_if.pll_locked_in      = 1'b0;
        u_if.pll_locked_stdy_in = 1'b0;
        tick();
        tick();
        u_if.restart_req = 1'b1;
        tick();
        u_if.restart_req = 1'b0;
        check("restart_state",   int'(u_if.state_out),     int'(ST_RESET_HOLD));
        check("restart_count",   int'(u_if.unlock_count),  1);
        check("restart_sys_rst", int'(u_if.sys_rst_n_out), 0);
        check("restart_ready",   int'(u_if.ready),         0);
        check("restart_timeout", int'(u_if.lock_timeout),  1);
        // A second request during the hold must not extend it.
        tick();
        u_if.restart_req = 1'b1;
        tick();
        u_if.restart_req = 1'b0;
        tick();
        check("hold_not_restarted_rh", int'(u_if.state_out), int'(ST_RESET_HOLD));
        tick();
        check("hold_not_restarted_wl", int'(u_if.state_out), int'(ST_WAIT_LOCK));

        // ---- 5b. asynchronous reset in the middle of ARM
        u_if.pll_locked_in = 1'b1;
        wait_state("arm_for_reset", int'(ST_ARM), 100);
        tick();
        check("arm_stdy_rst_high", int'(u_if.pll_stdy_rst), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences bring-up of a CC_PLL instance and supervises its lock for the rest of the design.
- Runs on the free-running PLL reference clock. It synchronizes the PLL lock flags, waits for a stable lock, then pulses the PLL's steady-lock reset (USR_LOCKED_STDY_RST) to arm steady-lock tracking.
- Only then releases the downstream system reset. It re-asserts that reset on any lock loss and counts the losses.
- Sits beside the PLL/BUFG wrapper; its reset output is re-synchronized into each consumer clock domain by the consumer.

Parameters:
- HOLD_CYCLES, 16, cycles the PLL is held in RESET_HOLD after reset or restart_req.
- SETTLE_CYCLES, 1024, consecutive synchronized-lock cycles required before arming.
- STDY_RST_CYCLES, 4, width of the pll_stdy_rst pulse; must be >=2.
- LOCK_TIMEOUT, 100000, WAIT_LOCK cycles before lock_timeout is flagged.
- CNT_W, 8, width of unlock_count.

Ports:
- clock_in  input  1  PLL reference clock, free-running.
- rst_n_in  input  1  asynchronous active-low reset.
- pll_locked_in  input  1  USR_PLL_LOCKED, asynchronous to clock_in.
- pll_locked_stdy_in  input  1  USR_PLL_LOCKED_STDY, asynchronous to clock_in.
- restart_req  input  1  single-cycle request to re-run the sequence.
- pll_stdy_rst  output  1  drives USR_LOCKED_STDY_RST.
- sys_rst_n_out  output  1  active-low system reset to consumers.
- ready  output  1  high exactly while in RUN.
- lock_timeout  output  1  sticky flag: lock not reached within LOCK_TIMEOUT.
- unlock_count  output  CNT_W  saturating count of lock losses seen in RUN.
- state_out  output  3  current state encoding, for debug.

Behaviour:
- Synchronization:
  - pll_locked_in and pll_locked_stdy_in each pass through a 2-FF synchronizer; lock_s and stdy_s denote the synchronized values.
  - Synchronizer FFs reset to 0.
- Reset values, asserted asynchronously while rst_n_in=0:
  - state=RESET_HOLD, timer=0.
  - pll_stdy_rst=0, sys_rst_n_out=0, ready=0, lock_timeout=0, unlock_count=0.
- All outputs are registered.
- State machine, one shared down/up timer:
  - RESET_HOLD: count HOLD_CYCLES cycles, then go to WAIT_LOCK with timer cleared.
  - WAIT_LOCK: timer counts.
    - lock_s=1 -> SETTLE, timer cleared.
    - Timer reaching LOCK_TIMEOUT-1 sets lock_timeout (sticky until rst_n_in). The timer saturates and the FSM stays in WAIT_LOCK.
  - SETTLE: timer counts while lock_s=1.
    - lock_s=0 -> WAIT_LOCK, timer cleared, no count increment.
    - After SETTLE_CYCLES consecutive lock cycles -> ARM.
  - ARM: pll_stdy_rst=1 for exactly STDY_RST_CYCLES cycles.
    - lock_s=0 during ARM -> WAIT_LOCK, pll_stdy_rst=0 next cycle.
    - Otherwise -> CHECK.
  - CHECK: wait up to 8 cycles for stdy_s=1.
    - On stdy_s=1 -> RUN.
    - Still 0 after 8 cycles, or lock_s=0 -> WAIT_LOCK.
  - RUN: sys_rst_n_out=1, ready=1.
    - lock_s=0 or stdy_s=0 -> WAIT_LOCK. unlock_count increments, saturating at all-ones.
    - sys_rst_n_out=0 and ready=0 from the next cycle.
- sys_rst_n_out is low in every state except RUN.
- Latency:
  - pll_locked_in falling in RUN -> sys_rst_n_out low within 3 clock_in edges (2 sync + 1 register).
  - Entry into RUN -> sys_rst_n_out high on the same edge that registers state=RUN.
- restart_req:
  - From any state other than RESET_HOLD: go to RESET_HOLD, timer cleared, outputs return to their reset values except lock_timeout and unlock_count.
  - In RESET_HOLD: ignored (the hold is not restarted).
- Priority on a simultaneous restart_req and lock loss in RUN: the next state is RESET_HOLD, and unlock_count still increments.
- rst_n_in asserted mid-sequence: immediate return to reset values. Deassertion is taken synchronously by the FSM (the reset deassertion synchronizer is the integrator's responsibility).
- Timer width: $clog2 of max(HOLD_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT)+1. Timer is unsigned with no wrap.

Decomposition:
- Package pll_sup_pkg: state encodings RESET_HOLD=0, WAIT_LOCK=1, SETTLE=2, ARM=3, CHECK=4, RUN=5; CHECK_CYCLES=8 constant.
- Sub-module sync_2ff (1-bit, parameterizable reset value), instantiated twice.

Test Plan (HOLD=4, SETTLE=8, STDY=4, TIMEOUT=64, CNT_W=8):
1. Clean bring-up:
   - Stimulus: release rst_n_in; pll_locked_in=1 from cycle 10; stdy follows 2 cycles after pll_stdy_rst falls.
   - Required: pll_stdy_rst high exactly 4 cycles; sys_rst_n_out and ready rise together; unlock_count=0.
2. Glitchy lock:
   - Stimulus: lock drops for 1 cycle at settle cycle 5.
   - Required: back to WAIT_LOCK, settle restarts, unlock_count=0, no pll_stdy_rst pulse before 8 clean cycles.
3. Lock loss in RUN:
   - Stimulus: drop pll_locked_in.
   - Required: sys_rst_n_out low within 3 cycles, unlock_count=1; relock re-runs SETTLE/ARM.
   - Repeat 300 losses -> unlock_count saturates at 255.
4. Timeout:
   - Stimulus: pll_locked_in held 0.
   - Required: lock_timeout=1 at WAIT_LOCK cycle 64 and stays set; late lock still reaches RUN with lock_timeout still 1.
5. Restart and async reset:
   - restart_req in RUN together with lock loss -> state RESET_HOLD, unlock_count+1, sys_rst_n_out low next cycle.
   - rst_n_in low mid-ARM -> pll_stdy_rst=0 and all outputs at reset values without a clock edge.
